// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared types and helpers for the APB arbitrating master
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin grant
// Picks the first requester at or after ptr, wrapping NREQ-1 -> 0.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    int j;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - round-robin arbitrating APB master for NREQ requesters
// Optional ACCESS-phase timeout abort built when APB_TIMEOUT_EN is defined.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        done,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic [DATA_W-1:0]      PRDATA,
  input  logic                   PREADY
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  apb_state_e        state, state_d;
  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [IDX_W-1:0]  gidx, gidx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  gidx_next;

  logic              psel_d, penable_d, pwrite_d, err_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rdata_d;
  logic [NREQ-1:0]   done_d;

  logic [NREQ-1:0]   arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  apb_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req),
    .ptr         (ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign gidx_next = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = tmo_cnt_w(TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             tmo_hit;
  // Fires on the TIMEOUT-th ACCESS cycle without PREADY.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    gidx_d    = gidx;
    gnt_d     = gnt_q;
    psel_d    = PSEL;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    rdata_d   = rdata;
    done_d    = '0;
    err_d     = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt;
`endif

    case (state)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (arb_valid) begin
          gidx_d   = arb_idx;
          gnt_d    = arb_grant;
          pwrite_d = req_write[arb_idx];
          paddr_d  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
          psel_d   = 1'b1;
          state_d  = SETUP;
`ifdef APB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          if (!PWRITE) rdata_d = PRDATA;
          ptr_d     = gidx_next;
          state_d   = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q;
          err_d     = 1'b1;
          ptr_d     = gidx_next;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
`endif
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      gnt_q   <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      done    <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      gidx    <= gidx_d;
      gnt_q   <= gnt_d;
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
      rdata   <= rdata_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) tmo_cnt <= '0;
    else          tmo_cnt <= tmo_cnt_d;
  end
`endif

endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - directed scoreboard bench for apb_arb_master
// Timeout scenario is exercised when APB_TIMEOUT_EN is defined.
module tb_apb_arb_master;

  localparam int NREQ = 4;

  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [NREQ-1:0]   req, req_write;
  logic [NREQ*32-1:0] req_addr, req_wdata;
  logic [NREQ-1:0]   done;
  logic [31:0]       rdata, PADDR, PWDATA, PRDATA;
  logic              err, PSEL, PENABLE, PWRITE, PREADY;

  int          checks = 0;
  int          failures = 0;
  sb_t         sb[$];
  logic [31:0] model_rdata = '0;

  logic [NREQ-1:0] d;
  int cyc, psel_n, pen_n;

  apb_arb_master #(
    .NREQ(NREQ), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .rdata(rdata), .err(err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    req_write[i]          = wr;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = wd;
  endtask

  // Expected read data is taken from PRDATA at push time; aborts and writes keep the old value.
  task automatic expect_xfer(input int i, input logic er);
    sb_t e;
    e.idx   = i;
    e.wr    = req_write[i];
    e.addr  = req_addr[i*32 +: 32];
    e.wdata = req_wdata[i*32 +: 32];
    e.err   = er;
    e.rdata = (e.wr || er) ? model_rdata : PRDATA;
    model_rdata = e.rdata;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int waits, output logic [NREQ-1:0] dn,
                           output int c, output int ps, output int pe);
    int   acc;
    logic bad;
    sb_t  e;
    acc = 0; bad = 1'b0; dn = '0; c = 0; ps = 0; pe = 0;
    PREADY = 1'b0;
    e = sb[0];
    while (dn == '0 && c < 60) begin
      tick();
      c++;
      if (PSEL) begin
        ps++;
        if (PADDR !== e.addr || PWRITE !== e.wr || PWDATA !== e.wdata) bad = 1'b1;
      end
      if (PENABLE) begin
        pe++;
        acc++;
      end
      PREADY = (acc > waits);
      dn = done;
    end
    chk("done_within_bound", 64'(dn != '0), 64'(1));
    chk("bus_matches_request", 64'(bad), 64'(0));
  endtask

  task automatic pop_check(input logic [NREQ-1:0] dn);
    sb_t e;
    logic [NREQ-1:0] oh;
    e = sb.pop_front();
    oh = '0;
    oh[e.idx] = 1'b1;
    chk("done_onehot", 64'(dn), 64'(oh));
    chk("err", 64'(err), 64'(e.err));
    chk("rdata", 64'(rdata), 64'(e.rdata));
    chk("psel_low_at_done", 64'(PSEL), 64'(0));
    chk("penable_low_at_done", 64'(PENABLE), 64'(0));
  endtask

  initial begin
    PRESETn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0;
    tick(); tick();
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    PRESETn = 1'b1;

    // Single write, zero wait states
    set_fields(0, 1'b1, 32'h10, 32'hA5A5_0001);
    req = 4'b0001;
    expect_xfer(0, 1'b0);
    wait_done(0, d, cyc, psel_n, pen_n);
    pop_check(d);
    req = '0;
    chk("wr_latency", 64'(cyc), 64'(3));
    chk("wr_psel_cycles", 64'(psel_n), 64'(2));
    chk("wr_penable_cycles", 64'(pen_n), 64'(1));
    tick();
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("no_regrant_psel", 64'(PSEL), 64'(0));

    // Read with four wait states
    PRDATA = 32'h1234_5678;
    set_fields(2, 1'b0, 32'h40, 32'h0);
    req = 4'b0100;
    expect_xfer(2, 1'b0);
    wait_done(4, d, cyc, psel_n, pen_n);
    pop_check(d);
    req = '0;
    chk("rd_latency", 64'(cyc), 64'(7));
    chk("rd_psel_cycles", 64'(psel_n), 64'(6));
    chk("rd_penable_cycles", 64'(pen_n), 64'(5));

    // Wrap: pointer is now 3, requesters 3 and 0 pending
    PRDATA = 32'hBEEF_0003;
    set_fields(3, 1'b1, 32'h30, 32'h3333_0000);
    set_fields(0, 1'b0, 32'h00, 32'h0);
    req = 4'b1001;
    expect_xfer(3, 1'b0);
    expect_xfer(0, 1'b0);
    wait_done(0, d, cyc, psel_n, pen_n);
    pop_check(d);
    req = 4'b0001;
    wait_done(0, d, cyc, psel_n, pen_n);
    pop_check(d);
    req = '0;
    chk("wrap_gap", 64'(cyc), 64'(3));

    // Reset restores the pointer to 0, then full contention
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    chk("rdata_after_reset", 64'(rdata), 64'(0));
    model_rdata = '0;
    PRDATA = 32'hCAFE_0001;
    set_fields(0, 1'b1, 32'h100, 32'h0000_00D0);
    set_fields(1, 1'b0, 32'h104, 32'h0);
    set_fields(2, 1'b1, 32'h108, 32'h0000_00D2);
    set_fields(3, 1'b0, 32'h10C, 32'h0);
    req = 4'b1111;
    expect_xfer(0, 1'b0);
    expect_xfer(1, 1'b0);
    expect_xfer(2, 1'b0);
    expect_xfer(3, 1'b0);
    expect_xfer(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wait_done(0, d, cyc, psel_n, pen_n);
      if (k == 4) req = '0;
      pop_check(d);
      chk("contention_spacing", 64'(cyc), 64'(3));
    end

    // Reset during ACCESS drops the bus with no completion
    PREADY = 1'b0;
    set_fields(1, 1'b1, 32'h204, 32'h0000_0BAD);
    req = 4'b0010;
    tick(); tick();
    chk("mr_in_access", 64'(PENABLE), 64'(1));
    PRESETn = 1'b0;
    #1;
    chk("mr_psel", 64'(PSEL), 64'(0));
    chk("mr_penable", 64'(PENABLE), 64'(0));
    chk("mr_done", 64'(done), 64'(0));
    tick();
    model_rdata = '0;
    set_fields(0, 1'b1, 32'h200, 32'h0000_0600);
    req = 4'b0011;
    expect_xfer(0, 1'b0);
    PRESETn = 1'b1;
    wait_done(0, d, cyc, psel_n, pen_n);
    req = '0;
    pop_check(d);
    chk("mr_first_latency", 64'(cyc), 64'(3));

`ifdef APB_TIMEOUT_EN
    // PREADY never rises: abort after 8 ACCESS cycles
    PRDATA = 32'hDEAD_0000;
    set_fields(2, 1'b0, 32'h80, 32'h0);
    req = 4'b0100;
    expect_xfer(2, 1'b1);
    wait_done(1000, d, cyc, psel_n, pen_n);
    req = '0;
    pop_check(d);
    chk("tmo_access_cycles", 64'(pen_n), 64'(8));
    chk("tmo_latency", 64'(cyc), 64'(10));
    tick();
    chk("tmo_err_clears", 64'(err), 64'(0));
`endif

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- APB master that shares one APB bus between NREQ local requesters.
- Round-robin arbitration; runs the APB SETUP/ACCESS sequence for the granted requester and waits on PREADY.
- Returns a one-cycle done pulse and read data to the winning requester.
- Sits between on-chip requesters (DMA, CPU bridge, config engine) and the APB slave fabric; drives the bus signals the APB interface driver side carries.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 32, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT, 64, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  input  1  APB clock; all logic on its rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level.
- req_write  input  NREQ  per-requester 1=write, 0=read.
- req_addr  input  NREQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  input  NREQ*DATA_W  packed write data.
- done  output  NREQ  one-hot, one-cycle completion pulse.
- rdata  output  DATA_W  read data, valid when done is high.
- err  output  1  error flag, valid with done.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  ADDR_W  APB address.
- PWDATA  output  DATA_W  APB write data.
- PRDATA  input  DATA_W  APB read data.
- PREADY  input  1  APB ready.

Behaviour:
- Reset: asynchronous, active-low. Values: state IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA, rdata=0; done=0; err=0; RR pointer=0.
- Reset mid-transfer: bus is dropped immediately and no done is issued.
- All outputs are registered.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: if any req is high, grant the first requester at or after the RR pointer, wrapping from NREQ-1 to 0. Latch its addr, write and wdata into PADDR/PWRITE/PWDATA, set PSEL=1, go to SETUP. If no req, stay in IDLE with PSEL=0.
  - SETUP: exactly one cycle. Set PENABLE=1, go to ACCESS.
  - ACCESS: hold all bus outputs stable while PREADY=0. On PREADY=1:
    - Next cycle: PSEL=0, PENABLE=0, done[grant]=1 for one cycle, err=0.
    - If read: rdata<=PRDATA. If write: rdata is unchanged.
    - RR pointer <= (grant+1) mod NREQ. Go to IDLE.
- Minimum transfer: 3 cycles (IDLE→SETUP→ACCESS with PREADY=1). PSEL is low for at least one cycle between transfers.
- rdata holds its value until the next read completion.
- Requester contract: hold req and its fields stable from req rise until done. If req is still high in the cycle after done, it is a new request.
- Requests that arrive or drop while another requester owns the bus have no effect on the ongoing transfer.
- A req that drops before grant is ignored.
- Simultaneous requests are resolved purely by the RR pointer; there is no fixed priority.
- done is never asserted on more than one bit.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS. If PREADY stays 0 for TIMEOUT cycles, the transfer is aborted.
  - Abort response: PSEL and PENABLE drop, done[grant] pulses with err=1, rdata is unchanged, RR pointer advances, FSM goes to IDLE.
  - The counter clears on entry to SETUP.
- Undefined: no counter is built, err is tied 0, and ACCESS waits indefinitely.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum apb_state_e {IDLE, SETUP, ACCESS};
  - default ADDR_W and DATA_W localparams;
  - a timeout counter width function, clog2(TIMEOUT+1).
- Sub-module apb_rr_arbiter: combinational round-robin grant (req, pointer → one-hot grant plus index). Instantiated once.

Test Plan:
- Single write: req[0]=1, addr 0x10, wdata 0xA5A5_0001, PREADY=1 → PSEL high 2 cycles, PENABLE 1 cycle, done[0] pulses 3 cycles after req, err=0.
- Read with wait states: req[2] read 0x40, PREADY low 4 cycles, PRDATA=0x1234_5678 → bus stable through waits, done[2] with rdata=0x1234_5678.
- Contention: req=4'b1111 held → grants follow order 0,1,2,3,0, with one IDLE cycle between transfers.
- Wrap and fairness: pointer=3, req=4'b1001 → grant 3, then grant 0.
- Mid-transfer reset: PRESETn low during ACCESS → PSEL, PENABLE, done=0 immediately; after release, the first grant goes to requester 0.
- Timeout (APB_TIMEOUT_EN, TIMEOUT=8): PREADY held 0 → abort after 8 ACCESS cycles, done[g]=1 with err=1, rdata unchanged.
